// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg: segment patterns (a..g, bit6 = a) and decoded codes shared by the scan decoder.
package seg_scan_decoder_pkg;
   localparam int NUM_DIGITS = 8;
   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_B = 7'b0011111;
   localparam logic [6:0] SEG_C = 7'b1001110;
   localparam logic [6:0] SEG_D = 7'b0111101;
   localparam logic [6:0] SEG_E = 7'b1001111;
   localparam logic [6:0] SEG_F = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [4:0] CODE_BLANK = 5'h10;
   localparam logic [4:0] CODE_BAD = 5'h1F;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an {a..g,dp} pattern back to its hex code; blank and unknown patterns get reserved codes.
module seg7_pattern_decode
   import seg_scan_decoder_pkg::*;
(
   input  logic [7:0] i_pat,
   output logic [4:0] o_code,
   output logic       o_dp
);
   always_comb begin
      case (i_pat[7:1])
         SEG_0:     o_code = 5'h0;
         SEG_1:     o_code = 5'h1;
         SEG_2:     o_code = 5'h2;
         SEG_3:     o_code = 5'h3;
         SEG_4:     o_code = 5'h4;
         SEG_5:     o_code = 5'h5;
         SEG_6:     o_code = 5'h6;
         SEG_7:     o_code = 5'h7;
         SEG_8:     o_code = 5'h8;
         SEG_9:     o_code = 5'h9;
         SEG_A:     o_code = 5'hA;
         SEG_B:     o_code = 5'hB;
         SEG_C:     o_code = 5'hC;
         SEG_D:     o_code = 5'hD;
         SEG_E:     o_code = 5'hE;
         SEG_F:     o_code = 5'hF;
         SEG_BLANK: o_code = CODE_BLANK;
         default:   o_code = CODE_BAD;
      endcase
   end
   assign o_dp = i_pat[0];
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: observes the scanned seven-segment bus, debounces each digit and keeps a decoded 8-digit image.
// Commits land one cycle after the run filter reaches STABLE_CYCLES; a held pattern commits only once.
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int         STABLE_CYCLES  = 4,
   parameter int         TIMEOUT_CYCLES = 200000,
   parameter logic [7:0] DIGIT_MASK     = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  seg_hi,
   input  logic [7:0]  seg_lo,
   input  logic [7:0]  sel,
   input  logic [2:0]  rd_idx,
   output logic [4:0]  rd_digit,
   output logic        rd_dp,
   output logic [39:0] digits_flat,
   output logic        update,
   output logic        frame_done,
   output logic [15:0] glitch_cnt,
   output logic        stale
);
   localparam int RW = $clog2(STABLE_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [7:0]    r_seg_hi, r_seg_lo, r_sel;
   logic [2:0]    r_last_idx, r_cm_idx, w_idx;
   logic [7:0]    r_last_pat, r_cm_pat, w_pat;
   logic [RW-1:0] r_run;
   logic          r_cm, w_valid, w_same, w_hit;
   logic [4:0]    r_img [NUM_DIGITS];
   logic [7:0]    r_dp, r_seen, w_bit, w_seen_n;
   logic [WW-1:0] r_wd;
   logic [4:0]    w_code;
   logic          w_dp, w_frame;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg_hi <= '0;
         r_seg_lo <= '0;
         r_sel    <= '0;
      end else begin
         r_seg_hi <= seg_hi;
         r_seg_lo <= seg_lo;
         r_sel    <= sel;
      end
   end
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) if (r_sel[i]) w_idx = 3'(i);
   end
   assign w_valid = (r_sel != 8'd0) && ((r_sel & (r_sel - 8'd1)) == 8'd0);
   assign w_pat   = w_idx[2] ? r_seg_hi : r_seg_lo;
   assign w_same  = (w_idx == r_last_idx) && (w_pat == r_last_pat);
   // Hit only on the transition into STABLE_CYCLES, so a saturated run never recommits.
   assign w_hit   = w_valid && (w_same ? (r_run == RW'(STABLE_CYCLES - 1)) : (STABLE_CYCLES == 1));
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_idx <= '0;
         r_last_pat <= '0;
         r_run      <= '0;
         glitch_cnt <= '0;
         r_cm       <= 1'b0;
         r_cm_idx   <= '0;
         r_cm_pat   <= '0;
      end else begin
         r_cm     <= w_hit;
         r_cm_idx <= w_idx;
         r_cm_pat <= w_pat;
         if (!w_valid) begin
            r_run      <= '0;
            glitch_cnt <= (glitch_cnt == 16'hFFFF) ? glitch_cnt : glitch_cnt + 16'd1;
         end else if (w_same) begin
            r_run <= (r_run == RW'(STABLE_CYCLES)) ? r_run : r_run + 1'b1;
         end else begin
            r_run      <= RW'(1);
            r_last_idx <= w_idx;
            r_last_pat <= w_pat;
         end
      end
   end
   seg7_pattern_decode u_dec (.i_pat(r_cm_pat), .o_code(w_code), .o_dp(w_dp));
   assign w_bit    = r_cm ? (8'd1 << r_cm_idx) : 8'd0;
   assign w_seen_n = r_seen | w_bit;
   assign w_frame  = r_cm && ((w_seen_n & DIGIT_MASK) == DIGIT_MASK);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) r_img[i] <= CODE_BLANK;
         r_dp       <= '0;
         r_seen     <= '0;
         update     <= 1'b0;
         frame_done <= 1'b0;
         r_wd       <= '0;
      end else begin
         update     <= r_cm && ({w_code, w_dp} != {r_img[r_cm_idx], r_dp[r_cm_idx]});
         frame_done <= w_frame;
         r_seen     <= w_frame ? 8'd0 : w_seen_n;
         r_wd       <= r_cm ? '0 : ((r_wd == WW'(TIMEOUT_CYCLES)) ? r_wd : r_wd + 1'b1);
         if (r_cm) begin
            r_img[r_cm_idx] <= w_code;
            r_dp[r_cm_idx]  <= w_dp;
         end
      end
   end
   assign stale    = (r_wd == WW'(TIMEOUT_CYCLES));
   assign rd_digit = r_img[rd_idx];
   assign rd_dp    = r_dp[rd_idx];
   always_comb begin
      digits_flat = '0;
      for (int i = 0; i < NUM_DIGITS; i++) digits_flat[5*i +: 5] = r_img[i];
   end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and random scans checked against a history-based model of the digit image.
module tb_seg_scan_decoder;
   localparam int SC = 4;
   localparam int TO = 50;
   localparam logic [7:0] MASK = 8'hFF;
   logic clk = 1'b0, reset = 1'b1;
   logic [7:0] seg_hi = '0, seg_lo = '0, sel = '0;
   logic [2:0] rd_idx = '0;
   logic [4:0] rd_digit;
   logic rd_dp, update, frame_done, stale;
   logic [39:0] digits_flat;
   logic [15:0] glitch_cnt;
   int total = 0, bad = 0;
   int n_upd = 0, n_frm = 0;
   logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
   int m_streak, m_glitch, m_since;
   bit m_have, m_pend, m_upd, m_frm;
   logic [2:0] m_last_idx, m_pidx;
   logic [7:0] m_last_pat, m_ppat, m_rsel, m_rhi, m_rlo, m_seen;
   logic [4:0] m_img [8];
   logic m_dpv [8];
   logic [39:0] saved;
   seg_scan_decoder #(.STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO), .DIGIT_MASK(MASK)) dut (
      .clk(clk), .reset(reset), .seg_hi(seg_hi), .seg_lo(seg_lo), .sel(sel), .rd_idx(rd_idx),
      .rd_digit(rd_digit), .rd_dp(rd_dp), .digits_flat(digits_flat), .update(update),
      .frame_done(frame_done), .glitch_cnt(glitch_cnt), .stale(stale));
   always #5 clk = ~clk;
   function automatic logic [4:0] m_code(input logic [7:0] p);
      if (p[7:1] == 7'd0) return 5'h10;
      for (int i = 0; i < 16; i++) if (tbl[i] == p[7:1]) return 5'(i);
      return 5'h1F;
   endfunction
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic m_reset();
      m_streak = 0; m_glitch = 0; m_since = 0; m_have = 0; m_pend = 0; m_upd = 0; m_frm = 0;
      m_rsel = '0; m_rhi = '0; m_rlo = '0; m_seen = '0;
      for (int i = 0; i < 8; i++) begin m_img[i] = 5'h10; m_dpv[i] = 1'b0; end
   endtask
   task automatic m_edge(input logic [7:0] s, input logic [7:0] hi, input logic [7:0] lo);
      logic [4:0] c;
      int idx;
      logic [7:0] p;
      m_upd = 0; m_frm = 0;
      if (m_pend) begin
         c = m_code(m_ppat);
         m_upd = (c !== m_img[m_pidx]) || (m_ppat[0] !== m_dpv[m_pidx]);
         m_img[m_pidx] = c;
         m_dpv[m_pidx] = m_ppat[0];
         m_seen[m_pidx] = 1'b1;
         if ((m_seen & MASK) == MASK) begin m_frm = 1; m_seen = '0; end
         m_since = 0;
      end else m_since++;
      m_pend = 0;
      if ($countones(m_rsel) != 1) begin
         m_streak = 0;
         if (m_glitch < 65535) m_glitch++;
      end else begin
         idx = 0;
         for (int i = 0; i < 8; i++) if (m_rsel[i]) idx = i;
         p = (idx >= 4) ? m_rhi : m_rlo;
         if (m_have && idx == int'(m_last_idx) && p == m_last_pat) m_streak++;
         else begin m_streak = 1; m_have = 1; m_last_idx = 3'(idx); m_last_pat = p; end
         m_pend = (m_streak == SC);
         m_pidx = 3'(idx); m_ppat = p;
      end
      m_rsel = s; m_rhi = hi; m_rlo = lo;
   endtask
   task automatic chk();
      logic [39:0] f;
      for (int i = 0; i < 8; i++) f[5*i +: 5] = m_img[i];
      check("update", 64'(update), 64'(m_upd));
      check("frame_done", 64'(frame_done), 64'(m_frm));
      check("glitch_cnt", 64'(glitch_cnt), 64'(m_glitch));
      check("stale", 64'(stale), 64'(m_since >= TO));
      check("digits_flat", 64'(digits_flat), 64'(f));
      check("rd_digit", 64'(rd_digit), 64'(m_img[rd_idx]));
      check("rd_dp", 64'(rd_dp), 64'(m_dpv[rd_idx]));
   endtask
   task automatic cyc(input logic [7:0] s, input logic [7:0] hi, input logic [7:0] lo);
      sel = s; seg_hi = hi; seg_lo = lo; rd_idx = 3'($urandom_range(0, 7));
      @(posedge clk);
      m_edge(s, hi, lo);
      @(negedge clk);
      chk();
      n_upd += int'(update);
      n_frm += int'(frame_done);
   endtask
   task automatic digit(input int d, input logic [7:0] pat, input int n);
      for (int k = 0; k < n; k++) begin
         if (d >= 4) cyc(8'd1 << d, pat, 8'($urandom));
         else cyc(8'd1 << d, 8'($urandom), pat);
      end
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(8'h00, 8'($urandom), 8'($urandom));
   endtask
   initial begin
      logic [39:0] exp_f;
      int d, kind, hold;
      logic [7:0] s, p;
      m_reset();
      repeat (2) @(negedge clk);
      chk();
      check("reset_flat", 64'(digits_flat), 64'({8{5'h10}}));
      reset = 1'b0;
      // single digit 0 commit
      n_upd = 0;
      for (int k = 0; k < 6; k++) cyc(8'h01, 8'h00, 8'b11111100);
      check("t1_digit0", 64'(digits_flat[4:0]), 64'd0);
      check("t1_upd_count", 64'(n_upd), 64'd1);
      // full scan 1..8
      n_frm = 0;
      for (int i = 0; i < 8; i++) digit(i, {tbl[i+1], 1'b0}, 4);
      idle(3);
      check("scan_frames", 64'(n_frm), 64'd1);
      for (int i = 0; i < 8; i++) exp_f[5*i +: 5] = 5'(i + 1);
      check("scan_flat", 64'(digits_flat), 64'(exp_f));
      // short hold on digit 2 must not commit
      digit(2, {tbl[9], 1'b0}, 3);
      digit(3, {tbl[4], 1'b0}, 4);
      idle(2);
      check("short_hold", 64'(digits_flat[14:10]), 64'd3);
      // glitch cycles
      n_upd = 0;
      cyc(8'h00, 8'h00, 8'h00); cyc(8'h00, 8'h00, 8'h00); cyc(8'h00, 8'h00, 8'h00);
      cyc(8'h11, 8'hFE, 8'hFE); cyc(8'h11, 8'hFE, 8'hFE);
      check("glitch_no_upd", 64'(n_upd), 64'd0);
      // identical rescan, then change digit 5
      n_upd = 0; n_frm = 0;
      for (int i = 0; i < 8; i++) digit(i, {tbl[i+1], 1'b0}, 4);
      idle(3);
      check("rescan_upd", 64'(n_upd), 64'd0);
      check("rescan_frames", 64'(n_frm), 64'd1);
      n_upd = 0;
      digit(5, {tbl[14], 1'b0}, 6);
      idle(2);
      check("d5_upd", 64'(n_upd), 64'd1);
      check("d5_code", 64'(digits_flat[29:25]), 64'hE);
      // watchdog
      saved = digits_flat;
      idle(55);
      check("stale_set", 64'(stale), 64'd1);
      check("stale_img", 64'(digits_flat), 64'(saved));
      digit(1, {tbl[7], 1'b1}, 6);
      check("stale_clr", 64'(stale), 64'd0);
      // random scanning
      for (int r = 0; r < 150; r++) begin
         d = $urandom_range(0, 7);
         kind = $urandom_range(0, 9);
         hold = $urandom_range(1, 6);
         s = (kind == 0) ? 8'h00 : (kind == 1) ? (8'h81 << $urandom_range(0, 6)) : (8'd1 << d);
         p = (kind < 8) ? {tbl[$urandom_range(0, 15)], 1'($urandom)} : 8'($urandom);
         for (int k = 0; k < hold; k++) begin
            if (d >= 4) cyc(s, p, 8'($urandom));
            else cyc(s, 8'($urandom), p);
         end
      end
      // asynchronous reset mid-run
      digit(6, {tbl[10], 1'b1}, 2);
      reset = 1'b1;
      #1;
      m_reset();
      chk();
      @(negedge clk);
      reset = 1'b0;
      digit(6, {tbl[10], 1'b1}, 6);
      check("post_reset", 64'(digits_flat[34:30]), 64'hA);
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
